neo_p2rom_fetch: RTL and testbench

- Downstream consumer of the banked P2 address produced by the SMA bank-switch stage.
- Converts 68K port-window reads (P2_ADDR + nPORTOE strobes) into 4-word burst reads from SDRAM.
- Returns PROM_DATA to the SMA data mux and holds the 68K through PORT_WAIT (feeds the DTACK delay logic).
- One-line (8-byte) read buffer avoids refetching sequential words.

---
 rtl/neo_p2rom_pkg.sv | 11 +
 rtl/neo_strobe_sync.sv | 19 +
 rtl/neo_p2rom_fetch.sv | 146 ++++++++++++++
 tb/tb_neo_p2rom_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_p2rom_pkg.sv
// Shared types and constants for the P2 ROM fetch path.
package neo_p2rom_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, FETCH, HOLD} state_t;

  localparam int LINE_BYTES = 8;
  localparam int TAG_W      = 21;

  function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction
endpackage

// File: rtl/neo_strobe_sync.sv
// Two-flop synchroniser for an active-low port strobe with falling-edge detect.
module neo_strobe_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic strobe_n_i,
  output logic level_o,
  output logic fall_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], strobe_n_i};
  end

  // sync_q[2] is the previous synchronised level, used only for edge detect
  assign level_o = sync_q[1];
  assign fall_o  = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/neo_p2rom_fetch.sv
// 68K P2 port-window reads served from a one-line SDRAM buffer, with 4-word burst refill.
module neo_p2rom_fetch
  import neo_p2rom_pkg::*;
#(
  parameter logic [23:0] P2_BASE = 24'h200000,
  parameter int          TIMEOUT = 64
) (
  input  logic        nRESET,
  input  logic        CLK_24M,
  input  logic [23:0] P2_ADDR,
  input  logic        nPORTOEL,
  input  logic        nPORTOEU,
  input  logic        INVALIDATE,
  output logic [15:0] PROM_DATA,
  output logic        PORT_WAIT,
  output logic [23:0] SDRAM_ADDR,
  output logic        SDRAM_RD,
  input  logic        SDRAM_READY,
  input  logic [63:0] SDRAM_DQ
);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [23:1]        phys_q, phys_d;
  logic [63:0]        line_q, line_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               valid_q, valid_d;
  logic [15:0]        prom_q, prom_d;
  logic               wait_q, wait_d;
  logic               rd_q, rd_d;
  logic [23:0]        saddr_q, saddr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               oe_lvl, oe_fall;
  logic [23:0]        phys_new;
  logic [TAG_W-1:0]   cur_tag;
  logic [1:0]         cur_word;
  logic               hit;
  logic               unused_addr0;

  assign unused_addr0 = P2_ADDR[0];

  neo_strobe_sync u_oe_sync (
    .clk_i      (CLK_24M),
    .rst_n_i    (nRESET),
    .strobe_n_i (nPORTOEL & nPORTOEU),
    .level_o    (oe_lvl),
    .fall_o     (oe_fall)
  );

  // Wraps modulo 2^24; carry-out intentionally dropped
  assign phys_new = P2_BASE + {P2_ADDR[23:1], 1'b0};
  assign cur_tag  = phys_q[23:3];
  assign cur_word = phys_q[2:1];
  assign hit      = valid_q && (tag_q == cur_tag) && !INVALIDATE;

  always_comb begin
    state_d = state_q;
    phys_d  = phys_q;
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    prom_d  = prom_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    saddr_d = saddr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (oe_fall) begin
          phys_d  = phys_new[23:1];
          wait_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          prom_d  = line_word(line_q, cur_word);
          wait_d  = 1'b0;
          state_d = HOLD;
        end else begin
          saddr_d = {cur_tag, 3'b000};
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (SDRAM_READY) begin
          line_d  = SDRAM_DQ;
          valid_d = 1'b1;
          tag_d   = cur_tag;
          prom_d  = line_word(SDRAM_DQ, cur_word);
          rd_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rd_d    = 1'b0;
          prom_d  = 16'hFFFF;
          wait_d  = 1'b0;
          valid_d = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (oe_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Invalidate wins over any fill, including one completing this cycle
    if (INVALIDATE) valid_d = 1'b0;
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      phys_q  <= '0;
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      prom_q  <= 16'hFFFF;
      wait_q  <= 1'b0;
      rd_q    <= 1'b0;
      saddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phys_q  <= phys_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      prom_q  <= prom_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      saddr_q <= saddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PROM_DATA  = prom_q;
  assign PORT_WAIT  = wait_q;
  assign SDRAM_RD   = rd_q;
  assign SDRAM_ADDR = saddr_q;
endmodule

// File: tb/tb_neo_p2rom_fetch.sv
// Scoreboard bench for neo_p2rom_fetch: expected SDRAM addresses and read data queued per access.
module tb_neo_p2rom_fetch;
  logic        nRESET = 1'b0;
  logic        CLK_24M = 1'b0;
  logic [23:0] P2_ADDR = '0;
  logic        nPORTOEL = 1'b1;
  logic        nPORTOEU = 1'b1;
  logic        INVALIDATE = 1'b0;
  logic [15:0] PROM_DATA;
  logic        PORT_WAIT;
  logic [23:0] SDRAM_ADDR;
  logic        SDRAM_RD;
  logic        SDRAM_READY = 1'b0;
  logic [63:0] SDRAM_DQ = '0;

  int n_pass = 0;
  int n_total = 0;
  logic [23:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  neo_p2rom_fetch dut (
    .nRESET(nRESET), .CLK_24M(CLK_24M), .P2_ADDR(P2_ADDR),
    .nPORTOEL(nPORTOEL), .nPORTOEU(nPORTOEU), .INVALIDATE(INVALIDATE),
    .PROM_DATA(PROM_DATA), .PORT_WAIT(PORT_WAIT), .SDRAM_ADDR(SDRAM_ADDR),
    .SDRAM_RD(SDRAM_RD), .SDRAM_READY(SDRAM_READY), .SDRAM_DQ(SDRAM_DQ)
  );

  always #20 CLK_24M = ~CLK_24M;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK_24M);
  endtask

  task automatic start_read(input logic [23:0] a);
    @(negedge CLK_24M);
    P2_ADDR  = a;
    nPORTOEL = 1'b0;
  endtask

  task automatic end_read();
    @(negedge CLK_24M);
    nPORTOEL = 1'b1;
    nPORTOEU = 1'b1;
    cyc(5);
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_24M);
      if (SDRAM_RD) begin ok = 1'b1; break; end
    end
  endtask

  task automatic serve(input logic [63:0] dq);
    @(negedge CLK_24M);
    SDRAM_READY = 1'b1;
    SDRAM_DQ    = dq;
    @(negedge CLK_24M);
    SDRAM_READY = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3);
    if (PROM_DATA !== 16'hFFFF) $display("FAIL rst_data: got %h want ffff", PROM_DATA); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b0) $display("FAIL rst_wait: got %b want 0", PORT_WAIT); else n_pass++;
    n_total++;
    if (SDRAM_RD !== 1'b0) $display("FAIL rst_rd: got %b want 0", SDRAM_RD); else n_pass++;
    n_total++;
    if (SDRAM_ADDR !== 24'h0) $display("FAIL rst_addr: got %h want 000000", SDRAM_ADDR); else n_pass++;
    n_total++;
    nRESET = 1'b1;
    cyc(2);
  endtask

  task automatic test_miss();
    bit ok;
    logic [23:0] ea;
    logic [15:0] ed;
    exp_addr_q.push_back(24'h200010);
    exp_data_q.push_back(16'h1111);
    start_read(24'h000010);
    wait_rd(ok);
    if (ok !== 1'b1) $display("FAIL miss_rd: got %b want 1", ok); else n_pass++;
    n_total++;
    ea = exp_addr_q.pop_front();
    if (SDRAM_ADDR !== ea) $display("FAIL miss_addr: got %h want %h", SDRAM_ADDR, ea); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b1) $display("FAIL miss_wait: got %b want 1", PORT_WAIT); else n_pass++;
    n_total++;
    cyc(3);
    if (SDRAM_RD !== 1'b1) $display("FAIL miss_rd_held: got %b want 1", SDRAM_RD); else n_pass++;
    n_total++;
    serve(64'h4444_3333_2222_1111);
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL miss_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b0) $display("FAIL miss_wait_fall: got %b want 0", PORT_WAIT); else n_pass++;
    n_total++;
    if (SDRAM_RD !== 1'b0) $display("FAIL miss_rd_drop: got %b want 0", SDRAM_RD); else n_pass++;
    n_total++;
    end_read();
  endtask

  task automatic test_hit();
    int pw_cnt = 0;
    bit rd_seen = 1'b0;
    logic [15:0] ed;
    exp_data_q.push_back(16'h4444);
    start_read(24'h000016);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_24M);
      if (PORT_WAIT) pw_cnt++;
      if (SDRAM_RD) rd_seen = 1'b1;
    end
    if (pw_cnt !== 1) $display("FAIL hit_wait_cycles: got %0d want 1", pw_cnt); else n_pass++;
    n_total++;
    if (rd_seen !== 1'b0) $display("FAIL hit_no_rd: got %b want 0", rd_seen); else n_pass++;
    n_total++;
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL hit_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    end_read();
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 1;
    logic [23:0] ea;
    logic [15:0] ed;
    exp_addr_q.push_back(24'h300000);
    exp_data_q.push_back(16'hFFFF);
    start_read(24'h100000);
    wait_rd(ok);
    ea = exp_addr_q.pop_front();
    if (SDRAM_ADDR !== ea) $display("FAIL to_addr: got %h want %h", SDRAM_ADDR, ea); else n_pass++;
    n_total++;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_24M);
      if (!SDRAM_RD) break;
      n++;
    end
    if (n !== 64) $display("FAIL to_rd_cycles: got %0d want 64", n); else n_pass++;
    n_total++;
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL to_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b0) $display("FAIL to_wait: got %b want 0", PORT_WAIT); else n_pass++;
    n_total++;
    end_read();
    exp_addr_q.push_back(24'h300000);
    exp_data_q.push_back(16'hAAAA);
    start_read(24'h100000);
    wait_rd(ok);
    if (ok !== 1'b1) $display("FAIL to_repeat_miss: got %b want 1", ok); else n_pass++;
    n_total++;
    ea = exp_addr_q.pop_front();
    if (SDRAM_ADDR !== ea) $display("FAIL to_repeat_addr: got %h want %h", SDRAM_ADDR, ea); else n_pass++;
    n_total++;
    serve(64'h0000_0000_BBBB_AAAA);
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL to_repeat_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    end_read();
  endtask

  task automatic test_invalidate();
    bit ok;
    bit rd_seen = 1'b0;
    logic [23:0] ea;
    logic [15:0] ed;
    exp_data_q.push_back(16'hBBBB);
    start_read(24'h100002);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_24M);
      if (SDRAM_RD) rd_seen = 1'b1;
    end
    if (rd_seen !== 1'b0) $display("FAIL inv_prehit_rd: got %b want 0", rd_seen); else n_pass++;
    n_total++;
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL inv_prehit_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    end_read();
    INVALIDATE = 1'b1;
    cyc(1);
    INVALIDATE = 1'b0;
    exp_addr_q.push_back(24'h300000);
    exp_data_q.push_back(16'hCCCC);
    start_read(24'h100002);
    wait_rd(ok);
    if (ok !== 1'b1) $display("FAIL inv_miss: got %b want 1", ok); else n_pass++;
    n_total++;
    ea = exp_addr_q.pop_front();
    if (SDRAM_ADDR !== ea) $display("FAIL inv_addr: got %h want %h", SDRAM_ADDR, ea); else n_pass++;
    n_total++;
    serve(64'h0000_0000_CCCC_0000);
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL inv_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    end_read();
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    start_read(24'h000100);
    wait_rd(ok);
    if (ok !== 1'b1) $display("FAIL rmf_rd: got %b want 1", ok); else n_pass++;
    n_total++;
    #2 nRESET = 1'b0;
    #1;
    if (SDRAM_RD !== 1'b0) $display("FAIL rmf_rd_drop: got %b want 0", SDRAM_RD); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b0) $display("FAIL rmf_wait: got %b want 0", PORT_WAIT); else n_pass++;
    n_total++;
    if (PROM_DATA !== 16'hFFFF) $display("FAIL rmf_data: got %h want ffff", PROM_DATA); else n_pass++;
    n_total++;
    nPORTOEL = 1'b1;
    @(negedge CLK_24M);
    nRESET = 1'b1;
    cyc(2);
    serve(64'h5555_6666_7777_8888);
    cyc(1);
    if (PROM_DATA !== 16'hFFFF) $display("FAIL rmf_late_data: got %h want ffff", PROM_DATA); else n_pass++;
    n_total++;
    if (PORT_WAIT !== 1'b0) $display("FAIL rmf_late_wait: got %b want 0", PORT_WAIT); else n_pass++;
    n_total++;
    if (SDRAM_RD !== 1'b0) $display("FAIL rmf_late_rd: got %b want 0", SDRAM_RD); else n_pass++;
    n_total++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [23:0] ea;
    logic [15:0] ed;
    exp_addr_q.push_back(24'h1FFFF8);
    exp_data_q.push_back(16'h5678);
    start_read(24'hFFFFF8);
    wait_rd(ok);
    if (ok !== 1'b1) $display("FAIL wrap_rd: got %b want 1", ok); else n_pass++;
    n_total++;
    ea = exp_addr_q.pop_front();
    if (SDRAM_ADDR !== ea) $display("FAIL wrap_addr: got %h want %h", SDRAM_ADDR, ea); else n_pass++;
    n_total++;
    serve(64'h9ABC_DEF0_1234_5678);
    ed = exp_data_q.pop_front();
    if (PROM_DATA !== ed) $display("FAIL wrap_data: got %h want %h", PROM_DATA, ed); else n_pass++;
    n_total++;
    end_read();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_timeout();
    test_invalidate();
    test_reset_midfetch();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
